// File: rtl/vend_pkg.sv
// Shared definitions for the vending controller: FSM encoding and coin values.
// Pure declarations; no timing and no backpressure.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CREDIT   = 2'd1,
    DISPENSE = 2'd2,
    CHANGE   = 2'd3
  } vendStateT;

  localparam int COIN_5  = 5;
  localparam int COIN_10 = 10;
  localparam int COIN_25 = 25;
  localparam int NICKEL  = 5;

endpackage

// File: rtl/dispense_timer.sv
// Actuator on-time counter: Active is high for DISPENSE_CYCLES cycles after Start.
// Done flags the last Active cycle; no backpressure, Start restarts the count.
module dispense_timer #(
  parameter int DISPENSE_CYCLES = 50
) (
  input  logic Clk,
  input  logic nRst,
  input  logic Start,
  output logic Active,
  output logic Done
);

  localparam int CW = $clog2(DISPENSE_CYCLES + 1);

  logic [CW-1:0] count;

  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      count  <= '0;
      Active <= 1'b0;
    end else if (Start) begin
      count  <= CW'(DISPENSE_CYCLES);
      Active <= 1'b1;
    end else if (Active) begin
      count <= count - 1'b1;
      if (count == CW'(1)) Active <= 1'b0;
    end
  end

  assign Done = Active && (count == CW'(1));

endmodule

// File: rtl/vend_controller.sv
// Vending sequencer: credit accumulation, select arbitration, dispense timing, nickel change.
// All outputs registered, one cycle after the input pulse; no backpressure, late coins are rejected.
module vend_controller
  import vend_pkg::*;
#(
  parameter int NUM_ITEMS       = 4,
  parameter int CREDIT_W        = 8,
  parameter int MAX_CREDIT      = 200,
  parameter int DISPENSE_CYCLES = 50
) (
  input  logic                          Clk,
  input  logic                          nRst,
  input  logic                          Coin5Pulse,
  input  logic                          Coin10Pulse,
  input  logic                          Coin25Pulse,
  input  logic [NUM_ITEMS-1:0]          SelPulse,
  input  logic                          CancelPulse,
  input  logic [NUM_ITEMS*CREDIT_W-1:0] Price,
  output logic [CREDIT_W-1:0]           Credit,
  output logic                          Busy,
  output logic                          DispenseEn,
  output logic [2:0]                    DispenseItem,
  output logic                          ChangePulse,
  output logic                          CoinReject,
  output logic                          Insufficient
);

  localparam logic [CREDIT_W:0]   MAX_C  = (CREDIT_W + 1)'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] NICKEL_C = CREDIT_W'(NICKEL);

  vendStateT             state, stateNext;
  logic [CREDIT_W-1:0]   creditNext;
  logic [2:0]            itemNext;
  logic                  busyNext, changeNext, rejectNext, insuffNext;
  logic                  timerStart, timerDone;

  logic                  coinAny, coinMulti;
  logic [CREDIT_W:0]     coinVal, coinSum;
  logic                  selFound;
  logic [2:0]            selIdx;
  logic [CREDIT_W-1:0]   selPrice;

  dispense_timer #(.DISPENSE_CYCLES(DISPENSE_CYCLES)) uTimer (
    .Clk    (Clk),
    .nRst   (nRst),
    .Start  (timerStart),
    .Active (DispenseEn),
    .Done   (timerDone)
  );

  // Coin priority by value; the winner is checked against MAX_CREDIT one bit wider.
  always_comb begin
    coinAny   = Coin5Pulse | Coin10Pulse | Coin25Pulse;
    coinMulti = $countones({Coin5Pulse, Coin10Pulse, Coin25Pulse}) > 1;
    if (Coin25Pulse)      coinVal = (CREDIT_W + 1)'(COIN_25);
    else if (Coin10Pulse) coinVal = (CREDIT_W + 1)'(COIN_10);
    else if (Coin5Pulse)  coinVal = (CREDIT_W + 1)'(COIN_5);
    else                  coinVal = '0;
    coinSum = {1'b0, Credit} + coinVal;
  end

  always_comb begin
    selFound = 1'b0;
    selIdx   = '0;
    selPrice = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (SelPulse[i] && !selFound) begin
        selFound = 1'b1;
        selIdx   = 3'(i);
        selPrice = Price[i*CREDIT_W +: CREDIT_W];
      end
    end
  end

  always_comb begin
    stateNext  = state;
    creditNext = Credit;
    itemNext   = DispenseItem;
    changeNext = 1'b0;
    rejectNext = 1'b0;
    insuffNext = 1'b0;
    timerStart = 1'b0;
    case (state)
      IDLE, CREDIT: begin
        if (CancelPulse && state == CREDIT) begin
          stateNext  = CHANGE;
          changeNext = 1'b1;
          rejectNext = coinAny;
        end else if (selFound) begin
          rejectNext = coinAny;
          if (Credit >= selPrice) begin
            creditNext = Credit - selPrice;
            itemNext   = selIdx;
            stateNext  = DISPENSE;
            timerStart = 1'b1;
          end else begin
            insuffNext = 1'b1;
          end
        end else if (coinAny) begin
          rejectNext = coinMulti;
          if (coinSum > MAX_C) begin
            rejectNext = 1'b1;
          end else begin
            creditNext = coinSum[CREDIT_W-1:0];
            stateNext  = CREDIT;
          end
        end
      end
      DISPENSE: begin
        rejectNext = coinAny;
        if (timerDone) begin
          if (Credit != '0) begin
            stateNext  = CHANGE;
            changeNext = 1'b1;
          end else begin
            stateNext = IDLE;
          end
        end
      end
      CHANGE: begin
        rejectNext = coinAny;
        // Credit drops at the end of each pulse cycle; the gap cycle re-arms the pulse.
        if (ChangePulse) begin
          creditNext = Credit - NICKEL_C;
          if (creditNext == '0) stateNext = IDLE;
        end else begin
          changeNext = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
    busyNext = (stateNext == DISPENSE) || (stateNext == CHANGE);
  end

  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      state        <= IDLE;
      Credit       <= '0;
      Busy         <= 1'b0;
      DispenseItem <= '0;
      ChangePulse  <= 1'b0;
      CoinReject   <= 1'b0;
      Insufficient <= 1'b0;
    end else begin
      state        <= stateNext;
      Credit       <= creditNext;
      Busy         <= busyNext;
      DispenseItem <= itemNext;
      ChangePulse  <= changeNext;
      CoinReject   <= rejectNext;
      Insufficient <= insuffNext;
    end
  end

endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller with hand-computed expectations.
module tb_vend_controller;

  logic        Clk;
  logic        nRst;
  logic        Coin5Pulse, Coin10Pulse, Coin25Pulse;
  logic [3:0]  SelPulse;
  logic        CancelPulse;
  logic [31:0] Price;
  logic [7:0]  Credit;
  logic        Busy, DispenseEn, ChangePulse, CoinReject, Insufficient;
  logic [2:0]  DispenseItem;

  int vecs = 0;
  int errs = 0;

  vend_controller #(
    .NUM_ITEMS(4), .CREDIT_W(8), .MAX_CREDIT(200), .DISPENSE_CYCLES(50)
  ) dut (
    .Clk(Clk), .nRst(nRst),
    .Coin5Pulse(Coin5Pulse), .Coin10Pulse(Coin10Pulse), .Coin25Pulse(Coin25Pulse),
    .SelPulse(SelPulse), .CancelPulse(CancelPulse), .Price(Price),
    .Credit(Credit), .Busy(Busy), .DispenseEn(DispenseEn), .DispenseItem(DispenseItem),
    .ChangePulse(ChangePulse), .CoinReject(CoinReject), .Insufficient(Insufficient)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // One cycle of input pulses; outputs are observed #1 after the capturing edge.
  task automatic pulse(input logic c5, input logic c10, input logic c25,
                       input logic [3:0] sel, input logic cancel);
    Coin5Pulse = c5; Coin10Pulse = c10; Coin25Pulse = c25;
    SelPulse = sel; CancelPulse = cancel;
    tick();
    Coin5Pulse = 0; Coin10Pulse = 0; Coin25Pulse = 0;
    SelPulse = '0; CancelPulse = 0;
  endtask

  // Runs a change sequence that has just started; returns pulses seen and busy cycles.
  task automatic drain(output int pulses, output int cycles);
    pulses = 0;
    cycles = 0;
    for (int k = 0; k < 300; k++) begin
      if (!Busy) break;
      if (ChangePulse) pulses++;
      cycles++;
      tick();
    end
  endtask

  task automatic test_reset();
    nRst = 0;
    #2;
    vecs++; if (Credit !== 8'd0) begin errs++; $display("FAIL reset_credit: got %0d want 0", Credit); end
    vecs++; if (Busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", Busy); end
    vecs++; if (DispenseEn !== 1'b0) begin errs++; $display("FAIL reset_dispense_en: got %b want 0", DispenseEn); end
    vecs++; if ({DispenseItem, ChangePulse, CoinReject, Insufficient} !== 6'd0) begin
      errs++; $display("FAIL reset_misc: got %b want 000000", {DispenseItem, ChangePulse, CoinReject, Insufficient});
    end
    tick();
    nRst = 1;
    tick();
  endtask

  task automatic test_coin_accumulate();
    pulse(0, 0, 1, 4'b0000, 0);
    vecs++; if (Credit !== 8'd25) begin errs++; $display("FAIL coin25_credit: got %0d want 25", Credit); end
    pulse(0, 1, 0, 4'b0000, 0);
    vecs++; if (Credit !== 8'd35) begin errs++; $display("FAIL coin10_credit: got %0d want 35", Credit); end
    vecs++; if (CoinReject !== 1'b0 || Busy !== 1'b0) begin
      errs++; $display("FAIL coin_no_reject: got rej=%b busy=%b want 0 0", CoinReject, Busy);
    end
  endtask

  task automatic test_dispense();
    int highCycles;
    pulse(0, 0, 0, 4'b0110, 0);
    vecs++; if (Credit !== 8'd5) begin errs++; $display("FAIL sel_credit: got %0d want 5", Credit); end
    vecs++; if (DispenseItem !== 3'd1) begin errs++; $display("FAIL sel_item: got %0d want 1", DispenseItem); end
    vecs++; if (DispenseEn !== 1'b1 || Busy !== 1'b1) begin
      errs++; $display("FAIL sel_start: got en=%b busy=%b want 1 1", DispenseEn, Busy);
    end
    pulse(0, 1, 0, 4'b0000, 0);
    vecs++; if (CoinReject !== 1'b1 || Credit !== 8'd5) begin
      errs++; $display("FAIL busy_coin_reject: got rej=%b credit=%0d want 1 5", CoinReject, Credit);
    end
    highCycles = 2;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (!DispenseEn) break;
      highCycles++;
    end
    vecs++; if (highCycles !== 50) begin errs++; $display("FAIL dispense_len: got %0d want 50", highCycles); end
    vecs++; if (ChangePulse !== 1'b1 || Credit !== 8'd5 || Busy !== 1'b1) begin
      errs++; $display("FAIL change_first: got cp=%b credit=%0d busy=%b want 1 5 1", ChangePulse, Credit, Busy);
    end
    tick();
    vecs++; if (ChangePulse !== 1'b0 || Credit !== 8'd0 || Busy !== 1'b0) begin
      errs++; $display("FAIL change_done: got cp=%b credit=%0d busy=%b want 0 0 0", ChangePulse, Credit, Busy);
    end
  endtask

  task automatic test_multi_coin_and_limit();
    int pulses, cycles;
    pulse(1, 0, 1, 4'b0000, 0);
    vecs++; if (Credit !== 8'd25 || CoinReject !== 1'b1) begin
      errs++; $display("FAIL multi_coin: got credit=%0d rej=%b want 25 1", Credit, CoinReject);
    end
    tick();
    vecs++; if (CoinReject !== 1'b0) begin errs++; $display("FAIL reject_single: got %b want 0", CoinReject); end
    for (int k = 0; k < 6; k++) pulse(0, 0, 1, 4'b0000, 0);
    pulse(0, 1, 0, 4'b0000, 0);
    pulse(1, 0, 0, 4'b0000, 0);
    vecs++; if (Credit !== 8'd190) begin errs++; $display("FAIL fill_190: got %0d want 190", Credit); end
    pulse(0, 0, 1, 4'b0000, 0);
    vecs++; if (Credit !== 8'd190 || CoinReject !== 1'b1) begin
      errs++; $display("FAIL overflow_reject: got credit=%0d rej=%b want 190 1", Credit, CoinReject);
    end
    pulse(0, 1, 0, 4'b0000, 0);
    vecs++; if (Credit !== 8'd200 || CoinReject !== 1'b0) begin
      errs++; $display("FAIL max_accept: got credit=%0d rej=%b want 200 0", Credit, CoinReject);
    end
    pulse(0, 0, 0, 4'b0000, 1);
    drain(pulses, cycles);
    vecs++; if (pulses !== 40 || cycles !== 79) begin
      errs++; $display("FAIL refund_200: got pulses=%0d cycles=%0d want 40 79", pulses, cycles);
    end
    vecs++; if (Credit !== 8'd0) begin errs++; $display("FAIL refund_200_credit: got %0d want 0", Credit); end
  endtask

  task automatic test_insufficient_cancel();
    int pulses, cycles;
    pulse(0, 1, 0, 4'b0000, 0);
    pulse(0, 1, 0, 4'b0000, 0);
    pulse(0, 0, 0, 4'b0100, 0);
    vecs++; if (Insufficient !== 1'b1 || Credit !== 8'd20 || Busy !== 1'b0) begin
      errs++; $display("FAIL insufficient: got ins=%b credit=%0d busy=%b want 1 20 0", Insufficient, Credit, Busy);
    end
    tick();
    vecs++; if (Insufficient !== 1'b0) begin errs++; $display("FAIL insufficient_pulse: got %b want 0", Insufficient); end
    pulse(0, 0, 0, 4'b0001, 1);
    vecs++; if (ChangePulse !== 1'b1 || DispenseEn !== 1'b0 || Credit !== 8'd20) begin
      errs++; $display("FAIL cancel_beats_sel: got cp=%b en=%b credit=%0d want 1 0 20", ChangePulse, DispenseEn, Credit);
    end
    drain(pulses, cycles);
    vecs++; if (pulses !== 4 || cycles !== 7 || Credit !== 8'd0) begin
      errs++; $display("FAIL refund_20: got pulses=%0d cycles=%0d credit=%0d want 4 7 0", pulses, cycles, Credit);
    end
  endtask

  task automatic test_reset_mid_dispense();
    pulse(0, 0, 1, 4'b0000, 0);
    pulse(0, 0, 1, 4'b0000, 0);
    pulse(0, 1, 0, 4'b0000, 0);
    pulse(0, 0, 0, 4'b0010, 0);
    vecs++; if (Credit !== 8'd30 || DispenseEn !== 1'b1) begin
      errs++; $display("FAIL pre_reset_dispense: got credit=%0d en=%b want 30 1", Credit, DispenseEn);
    end
    for (int k = 0; k < 9; k++) tick();
    nRst = 0;
    #1;
    vecs++; if (DispenseEn !== 1'b0 || Busy !== 1'b0 || Credit !== 8'd0) begin
      errs++; $display("FAIL async_reset: got en=%b busy=%b credit=%0d want 0 0 0", DispenseEn, Busy, Credit);
    end
    tick();
    nRst = 1;
    tick();
    pulse(1, 0, 0, 4'b0000, 0);
    vecs++; if (Credit !== 8'd5 || CoinReject !== 1'b0 || DispenseEn !== 1'b0) begin
      errs++; $display("FAIL post_reset_coin: got credit=%0d rej=%b en=%b want 5 0 0", Credit, CoinReject, DispenseEn);
    end
  endtask

  initial begin
    Coin5Pulse = 0; Coin10Pulse = 0; Coin25Pulse = 0;
    SelPulse = '0; CancelPulse = 0;
    Price = {8'd100, 8'd25, 8'd30, 8'd50};
    nRst = 0;
    #3;
    test_reset();
    test_coin_accumulate();
    test_dispense();
    test_multi_coin_and_limit();
    test_insufficient_cancel();
    test_reset_mid_dispense();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
